// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// DEF_DONE_PC is also used as the branch LUT's default entry.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pc_state_t;

    localparam int PC_W         = 12;
    localparam int LUT_IDX_W    = 5;
    localparam int CNT_W        = 16;
    localparam int DEF_START_PC = 0;
    localparam int DEF_DONE_PC  = 71;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: taken branch or pc + 1.
// Also flags the terminal address and the top-of-range PC.
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int D       = PC_W,
    parameter int DONE_PC = DEF_DONE_PC
) (
    input  logic [D-1:0] pc,
    input  logic         br_en,
    input  logic         br_cond,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] pc_next,
    output logic         taken,
    output logic         hit_done,
    output logic         wrap
);

    localparam logic [D-1:0] DONE_V = D'(DONE_PC);

    assign taken    = br_en & br_cond;
    assign pc_next  = taken ? lut_target : pc + 1'b1;
    assign hit_done = (pc_next == DONE_V);
    // wrap means pc sits at the top of the range; the caller
    // combines it with !taken to detect a sequential wrap
    assign wrap     = (pc == {D{1'b1}});

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, fetch PC,
// branch-target LUT indexing and retired-instruction counter.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int D        = PC_W,
    parameter int A        = LUT_IDX_W,
    parameter int START_PC = DEF_START_PC,
    parameter int DONE_PC  = DEF_DONE_PC,
    parameter int CW       = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          br_en,
    input  logic          br_cond,
    input  logic [A-1:0]  br_idx,
    output logic [A-1:0]  lut_addr,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  pc,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [CW-1:0] instr_cnt
);

    localparam logic [D-1:0] START_V = D'(START_PC);

    pc_state_t     state, state_d;
    logic [D-1:0]  pc_d;
    logic [CW-1:0] cnt_d;
    logic          ovf_d;

    logic [D-1:0]  pc_next;
    logic          taken;
    logic          hit_done;
    logic          wrap;
    logic          seq_wrap;

    assign lut_addr = br_idx;

    pc_next_calc #(
        .D       (D),
        .DONE_PC (DONE_PC)
    ) u_next (
        .pc         (pc),
        .br_en      (br_en),
        .br_cond    (br_cond),
        .lut_target (lut_target),
        .pc_next    (pc_next),
        .taken      (taken),
        .hit_done   (hit_done),
        .wrap       (wrap)
    );

    assign seq_wrap = wrap & ~taken;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = instr_cnt;
        ovf_d   = overflow;
        unique case (state)
            IDLE: begin
                pc_d = START_V;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    pc_d  = pc_next;
                    cnt_d = (&instr_cnt) ? instr_cnt
                                         : instr_cnt + 1'b1;
                    if (hit_done) begin
                        state_d = DONE;
                    end else if (seq_wrap) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_V;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_V;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= START_V;
            instr_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            instr_cnt <= cnt_d;
            overflow  <= ovf_d;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer, including a
// second instance started near the top of the PC range.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stall, br_en, br_cond;
    logic [4:0]  br_idx, lut_addr;
    logic [11:0] lut_target, pc;
    logic        busy, done, overflow;
    logic [15:0] instr_cnt;

    logic        o_reset, o_start;
    logic [4:0]  o_idx, o_addr;
    logic [11:0] o_tgt, o_pc;
    logic        o_busy, o_done, o_ovf;
    logic [15:0] o_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pc_sequencer u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .br_en      (br_en),
        .br_cond    (br_cond),
        .br_idx     (br_idx),
        .lut_addr   (lut_addr),
        .lut_target (lut_target),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .instr_cnt  (instr_cnt)
    );

    pc_sequencer #(.START_PC(4094)) u_ovf (
        .clk        (clk),
        .reset      (o_reset),
        .start      (o_start),
        .stall      (1'b0),
        .br_en      (1'b0),
        .br_cond    (1'b0),
        .br_idx     (o_idx),
        .lut_addr   (o_addr),
        .lut_target (o_tgt),
        .pc         (o_pc),
        .busy       (o_busy),
        .done       (o_done),
        .overflow   (o_ovf),
        .instr_cnt  (o_cnt)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic br(input logic en, input logic c,
                      input logic [11:0] tgt);
        br_en      = en;
        br_cond    = c;
        lut_target = tgt;
    endtask

    task automatic st(input string tag, input logic [11:0] epc,
                      input logic eb, input logic ed,
                      input logic [15:0] ec);
        chk({tag, ".pc"},   32'(pc), 32'(epc));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".cnt"},  32'(instr_cnt), 32'(ec));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        br_idx = '0; br(1'b0, 1'b0, 12'd0);
        o_reset = 1'b1; o_start = 1'b0; o_idx = 5'd3; o_tgt = '0;
        step(2);
        st("rst", 12'd0, 1'b0, 1'b0, 16'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);

        reset = 1'b0; o_reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        st("start", 12'd0, 1'b1, 1'b0, 16'd0);
        step(5);
        st("seq5", 12'd5, 1'b1, 1'b0, 16'd5);
        step(5);
        st("seq10", 12'd10, 1'b1, 1'b0, 16'd10);

        br_idx = 5'd2; br(1'b1, 1'b1, 12'd26);
        #1 chk("lut_addr", 32'(lut_addr), 32'd2);
        step();
        st("taken", 12'd26, 1'b1, 1'b0, 16'd11);
        br(1'b1, 1'b1, 12'd10); step();
        br(1'b1, 1'b0, 12'd26); step();
        st("nottaken", 12'd11, 1'b1, 1'b0, 16'd13);

        br(1'b1, 1'b1, 12'd30); step();
        br(1'b1, 1'b1, 12'd50); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            st("stall", 12'd30, 1'b1, 1'b0, 16'd14);
        end
        stall = 1'b0; step();
        st("unstall", 12'd50, 1'b1, 1'b0, 16'd15);
        step();
        st("selfloop", 12'd50, 1'b1, 1'b0, 16'd16);

        br(1'b1, 1'b1, 12'd20); step();
        br(1'b1, 1'b1, 12'd71); step();
        st("br_done", 12'd71, 1'b0, 1'b1, 16'd18);
        br(1'b1, 1'b1, 12'd5); step(2);
        st("hold", 12'd71, 1'b0, 1'b1, 16'd18);

        br(1'b0, 1'b0, 12'd0);
        start = 1'b1; step(); start = 1'b0;
        st("restart", 12'd0, 1'b1, 1'b0, 16'd0);
        br(1'b1, 1'b1, 12'd70); step();
        br(1'b0, 1'b0, 12'd0); step();
        st("seq_done", 12'd71, 1'b0, 1'b1, 16'd2);

        start = 1'b1; step(); start = 1'b0;
        br(1'b1, 1'b1, 12'd40); step();
        st("at40", 12'd40, 1'b1, 1'b0, 16'd1);
        reset = 1'b1; start = 1'b1; br(1'b1, 1'b1, 12'd5);
        step();
        st("midrst", 12'd0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0; start = 1'b0; step();
        st("idle", 12'd0, 1'b0, 1'b0, 16'd0);

        o_start = 1'b1; step(); o_start = 1'b0;
        chk("ovf.start", 32'(o_pc), 32'd4094);
        step();
        chk("ovf.top", 32'(o_pc), 32'd4095);
        chk("ovf.flag0", 32'(o_ovf), 32'd0);
        step();
        chk("ovf.pc", 32'(o_pc), 32'd0);
        chk("ovf.flag", 32'(o_ovf), 32'd1);
        chk("ovf.done", 32'(o_done), 32'd1);
        chk("ovf.busy", 32'(o_busy), 32'd0);
        chk("ovf.cnt", 32'(o_cnt), 32'd2);
        chk("ovf.addr", 32'(o_addr), 32'd3);
        step();
        chk("ovf.hold", 32'(o_ovf), 32'd1);
        o_start = 1'b1; step(); o_start = 1'b0;
        chk("ovf.clr", 32'(o_ovf), 32'd0);
        chk("ovf.repc", 32'(o_pc), 32'd4094);
        chk("ovf.rebusy", 32'(o_busy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer that consumes branch targets from the processor's 5-bit-indexed branch-target lookup table.
- Drives the LUT index, receives the absolute target and produces the fetch PC each cycle.
- Owns program start/stop: leaves IDLE on a start pulse and raises done when the PC reaches the program's terminal address.
- Sits between the control decoder (branch request, index, condition flag) and instruction memory (PC).

Parameters:
- D, 12, PC / target width in bits.
- A, 5, LUT index width (up to 32 targets).
- START_PC, 0, PC value loaded on reset and on start.
- DONE_PC, 71, terminal PC; reaching it ends the program.
- CW, 16, width of the executed-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a program run from START_PC.
- stall  input  1  when high in RUN, holds PC and counters.
- br_en  input  1  current instruction is a LUT branch.
- br_cond  input  1  branch condition flag; a branch is taken only when br_en and br_cond are both 1.
- br_idx  input  A  LUT index carried by the current instruction.
- lut_addr  output  A  index to the branch-target LUT; combinational copy of br_idx.
- lut_target  input  D  absolute target returned by the LUT in the same cycle (the LUT is combinational).
- pc  output  D  current fetch address (registered).
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- overflow  output  1  sticky; PC wrapped past 2^D-1 without reaching DONE_PC.
- instr_cnt  output  CW  instructions retired this run; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high; takes priority over every other input, including mid-run):
  - state = IDLE, pc = START_PC, done = 0, busy = 0, overflow = 0, instr_cnt = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - pc holds START_PC; br_en and stall are ignored.
  - On start = 1: next state RUN, pc = START_PC, instr_cnt = 0, overflow = 0.
- RUN, stall = 1: pc and instr_cnt hold; start is ignored.
- RUN, stall = 0, one retire per cycle:
  - Next-PC: if br_en && br_cond, pc_next = lut_target; otherwise pc_next = pc + 1.
  - instr_cnt increments by 1 (saturating).
  - If pc_next == DONE_PC, next state DONE and pc = DONE_PC. This applies to both the taken-branch and sequential paths; done rises on the same edge pc becomes DONE_PC.
  - If pc == 2^D-1 and the sequential path is taken, pc wraps to 0, overflow is set, and next state DONE.
  - start is ignored in RUN.
- Branch rules:
  - A taken branch has one-cycle latency: the target appears on pc at the next edge.
  - A not-taken branch (br_en = 1, br_cond = 0) behaves as pc + 1.
  - A branch to the current pc is legal and loops until br_cond falls.
  - lut_target is sampled only when the branch is taken.
- DONE:
  - pc holds its final value; done = 1 and busy = 0; instr_cnt and overflow hold.
  - On start = 1: RUN, pc = START_PC, instr_cnt = 0, overflow = 0, done = 0.
- Simultaneous events:
  - reset beats start.
  - stall beats branch.
  - The DONE_PC check uses pc_next after the branch/sequential choice.
- Arithmetic: pc + 1 is D-bit modulo; instr_cnt never wraps.
- Outputs are registered except lut_addr.

Decomposition:
- Shared package pc_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
  - localparams PC_W = 12, LUT_IDX_W = 5;
  - DONE_PC default constant, shared with the LUT's default entry so the two stay aligned.
- One natural sub-module: pc_next_calc (combinational). Computes pc_next, taken, hit_done and wrap from pc, br_en, br_cond and lut_target.
- The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then start: reset for 2 cycles, then start pulse → pc = 0, busy = 1. After 5 un-stalled cycles with br_en = 0, pc = 5 and instr_cnt = 5.
- Taken branch: at pc = 10, br_en = 1, br_cond = 1, br_idx = 2, lut_target = 26 → lut_addr = 2 in the same cycle; pc = 26 at the next edge. Same stimulus with br_cond = 0 → pc = 11.
- Stall: at pc = 30, stall high for 3 cycles with br_en = 1 and br_cond = 1 → pc stays 30 and instr_cnt unchanged. After stall drops, the branch is taken.
- Termination: sequential run from pc = 70 → pc = 71, done = 1, busy = 0 on the same edge. Branch with lut_target = 71 from pc = 20 → done next edge. A further start pulse → pc = 0, done = 0.
- Overflow (D = 12): set START_PC = 4094, DONE_PC = 71 and run sequentially → pc 4095 → 0, overflow = 1, DONE. Overflow clears on the next start.
- Reset mid-run: assert reset at pc = 40 together with start and br_en → next edge: IDLE, pc = 0, instr_cnt = 0, done = 0, busy = 0.
